filter_grid_compositor: RTL and testbench

// - Parametrised NUM_ROWS x NUM_COLS filter-preview compositor for the 1024x768 display path.
// - Each cell shows one filtered image (one 12-bit channel per cell) inside a separator grid.
// - Owns a frame-synchronous selection cursor driven by left/right buttons, drawn as a highlight border.
// - Drives a shared image-relative read address for the per-cell frame buffers.

---
 rtl/filter_grid_compositor.sv | 169 ++++++++++++++++
 tb/tb_filter_grid_compositor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_grid_compositor.sv
// NUM_ROWS x NUM_COLS filter-preview compositor: separator grid, per-cell image, frame-synchronous cursor ring.
// Optional confirm/lock FSM enabled by defining GRID_CONFIRM_EN.
module filter_grid_compositor #(
    parameter int          NUM_COLS   = 3,
    parameter int          NUM_ROWS   = 2,
    parameter int          CELL_W     = 340,
    parameter int          CELL_H     = 384,
    parameter int          IMG_W      = 240,
    parameter int          IMG_H      = 320,
    parameter int          IMG_X_OFF  = 50,
    parameter int          IMG_Y_OFF  = 32,
    parameter int          BORDER_W   = 4,
    parameter int          V_ACTIVE   = 768,
    parameter logic [11:0] SEP_COLOR  = 12'hFFF,
    parameter logic [11:0] HI_COLOR   = 12'hF00,
    parameter logic [11:0] LOCK_COLOR = 12'h0F0,
    localparam int         NUM_CELLS  = NUM_ROWS * NUM_COLS,
    localparam int         SEL_W      = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1,
    localparam int         ADDR_W     = $clog2(IMG_W * IMG_H)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ready,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    left_in,
    input  logic                    right_in,
`ifdef GRID_CONFIRM_EN
    input  logic                    confirm_in,
`endif
    input  logic [NUM_CELLS*12-1:0] cell_pixel_in,
    output logic [ADDR_W-1:0]       img_addr_out,
    output logic [11:0]             pixel_out,
    output logic [SEL_W-1:0]        select_out,
    output logic                    locked_out
);

    typedef enum logic [1:0] {MV_NONE, MV_PREV, MV_NEXT} move_t;
    typedef enum logic [1:0] {REG_BG, REG_SEP, REG_IMG, REG_HI} region_t;
    typedef enum logic {ST_BROWSE, ST_LOCKED} lock_state_t;

    logic              left_q_reg, right_q_reg;
    move_t             pending_reg;
    logic [SEL_W-1:0]  select_reg;
    region_t           region_reg, region_next;
    logic [SEL_W-1:0]  cell_reg, cell_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [11:0]       pixel_reg;
    logic              locked;

    logic              left_press, right_press, press_valid, commit;
    move_t             press_move;
    logic [11:0]       cell_pix [NUM_CELLS];

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        assign cell_pix[gi] = cell_pixel_in[gi*12 +: 12];
    end

`ifdef GRID_CONFIRM_EN
    lock_state_t state_reg;
    logic        confirm_q_reg;
    assign locked = (state_reg == ST_LOCKED);
`else
    assign locked = 1'b0;
`endif

    // Presses are discarded while locked; simultaneous left+right is not a move.
    assign left_press  = left_in & ~left_q_reg & ~locked;
    assign right_press = right_in & ~right_q_reg & ~locked;
    assign press_valid = left_press ^ right_press;
    assign press_move  = left_press ? MV_PREV : MV_NEXT;
    assign commit      = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE)) && ready;

    int   h_pos, v_pos, col_idx, row_idx, loc_x, loc_y, cell_idx;
    logic in_grid, on_sep, in_img, in_ring;

    // Stage-1 region decode; cell position found with compare chains.
    always_comb begin
        h_pos   = int'(hcount_in);
        v_pos   = int'(vcount_in);
        col_idx = 0;
        row_idx = 0;
        for (int c = 1; c < NUM_COLS; c++) if (h_pos >= c * CELL_W) col_idx = c;
        for (int r = 1; r < NUM_ROWS; r++) if (v_pos >= r * CELL_H) row_idx = r;
        loc_x    = h_pos - col_idx * CELL_W;
        loc_y    = v_pos - row_idx * CELL_H;
        cell_idx = row_idx * NUM_COLS + col_idx;
        in_grid  = (h_pos < NUM_COLS * CELL_W) && (v_pos < NUM_ROWS * CELL_H);
        on_sep   = 1'b0;
        for (int c = 1; c < NUM_COLS; c++) if (h_pos == c * CELL_W) on_sep = 1'b1;
        for (int r = 1; r < NUM_ROWS; r++) if (v_pos == r * CELL_H - 1) on_sep = 1'b1;
        in_img  = (loc_x >= IMG_X_OFF) && (loc_x < IMG_X_OFF + IMG_W) &&
                  (loc_y >= IMG_Y_OFF) && (loc_y < IMG_Y_OFF + IMG_H);
        in_ring = (loc_x >= IMG_X_OFF - BORDER_W) && (loc_x < IMG_X_OFF + IMG_W + BORDER_W) &&
                  (loc_y >= IMG_Y_OFF - BORDER_W) && (loc_y < IMG_Y_OFF + IMG_H + BORDER_W);
        cell_next   = SEL_W'(cell_idx);
        region_next = REG_BG;
        addr_next   = '0;
        if (in_grid) begin
            if (on_sep) begin
                region_next = REG_SEP;
            end else if (in_img) begin
                region_next = REG_IMG;
                addr_next   = ADDR_W'((loc_y - IMG_Y_OFF) * IMG_W + (loc_x - IMG_X_OFF));
            end else if (in_ring && (cell_idx == int'(select_reg))) begin
                region_next = REG_HI;
            end
        end
        if (!ready) region_next = REG_BG;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            left_q_reg  <= 1'b0;
            right_q_reg <= 1'b0;
            pending_reg <= MV_NONE;
            select_reg  <= '0;
            region_reg  <= REG_BG;
            cell_reg    <= '0;
            addr_reg    <= '0;
            pixel_reg   <= '0;
`ifdef GRID_CONFIRM_EN
            confirm_q_reg <= 1'b0;
            state_reg     <= ST_BROWSE;
`endif
        end else begin
            left_q_reg  <= left_in;
            right_q_reg <= right_in;
            if (commit) begin
                case (pending_reg)
                    MV_NEXT: select_reg <= (select_reg == SEL_W'(NUM_CELLS - 1)) ? '0 : select_reg + 1'b1;
                    MV_PREV: select_reg <= (select_reg == '0) ? SEL_W'(NUM_CELLS - 1) : select_reg - 1'b1;
                    default: ;
                endcase
                // A press landing on the commit cycle waits for the next frame.
                pending_reg <= press_valid ? press_move : MV_NONE;
            end else if (press_valid) begin
                pending_reg <= press_move;
            end
`ifdef GRID_CONFIRM_EN
            confirm_q_reg <= confirm_in;
            if (confirm_in && !confirm_q_reg) begin
                case (state_reg)
                    ST_BROWSE: begin
                        state_reg   <= ST_LOCKED;
                        pending_reg <= MV_NONE;
                    end
                    default: state_reg <= ST_BROWSE;
                endcase
            end
`endif
            region_reg <= region_next;
            cell_reg   <= cell_next;
            addr_reg   <= addr_next;
            case (region_reg)
                REG_SEP: pixel_reg <= SEP_COLOR;
                REG_IMG: pixel_reg <= cell_pix[cell_reg];
                REG_HI:  pixel_reg <= locked ? LOCK_COLOR : HI_COLOR;
                default: pixel_reg <= 12'h000;
            endcase
        end
    end

    assign img_addr_out = addr_reg;
    assign pixel_out    = pixel_reg;
    assign select_out   = select_reg;
    assign locked_out   = locked;

endmodule

// File: tb/tb_filter_grid_compositor.sv
// Directed bench for filter_grid_compositor: raster positions and button sequences driven step by step.
module tb_filter_grid_compositor;

    logic        clk_in = 1'b0;
    logic        rst_in, ready, left_in, right_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [71:0] cell_pixel_in;
    logic [16:0] img_addr_out;
    logic [11:0] pixel_out;
    logic [2:0]  select_out;
    logic        locked_out;
`ifdef GRID_CONFIRM_EN
    logic        confirm_in;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    filter_grid_compositor dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .ready         (ready),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .left_in       (left_in),
        .right_in      (right_in),
`ifdef GRID_CONFIRM_EN
        .confirm_in    (confirm_in),
`endif
        .cell_pixel_in (cell_pixel_in),
        .img_addr_out  (img_addr_out),
        .pixel_out     (pixel_out),
        .select_out    (select_out),
        .locked_out    (locked_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input int h, input int v, input logic [11:0] exp, input string tag);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        step();
        step();
        check(tag, 32'(pixel_out), 32'(exp));
    endtask

    task automatic press_right();
        right_in = 1'b1;
        step();
        right_in = 1'b0;
        step();
    endtask

    task automatic press_left();
        left_in = 1'b1;
        step();
        left_in = 1'b0;
        step();
    endtask

    task automatic commit();
        hcount_in = 11'd0;
        vcount_in = 10'd768;
        step();
        hcount_in = 11'd1;
        step();
    endtask

    initial begin
        rst_in        = 1'b1;
        ready         = 1'b0;
        hcount_in     = 11'd0;
        vcount_in     = 10'd0;
        left_in       = 1'b0;
        right_in      = 1'b0;
`ifdef GRID_CONFIRM_EN
        confirm_in    = 1'b0;
`endif
        cell_pixel_in = {12'h555, 12'h444, 12'h333, 12'h222, 12'h111, 12'hABC};
        step();
        step();
        check("rst_pixel", 32'(pixel_out), 32'h0);
        check("rst_addr", 32'(img_addr_out), 32'h0);
        check("rst_select", 32'(select_out), 32'h0);
        check("rst_locked", 32'(locked_out), 32'h0);

        rst_in = 1'b0;
        ready  = 1'b1;
        // Latency: image pixel at (50,32) then background; data shows exactly 2 edges later.
        hcount_in = 11'd50;   vcount_in = 10'd32;  step();
        check("addr_origin", 32'(img_addr_out), 32'd0);
        hcount_in = 11'd1000; vcount_in = 10'd100; step();
        check("pix_lat2", 32'(pixel_out), 32'hABC);
        step();
        check("pix_after", 32'(pixel_out), 32'h000);
        hcount_in = 11'd289;  vcount_in = 10'd351; step();
        check("addr_last", 32'(img_addr_out), 32'd76799);
        hcount_in = 11'd440;  vcount_in = 10'd484; step();
        check("addr_cell4", 32'(img_addr_out), 32'd16370);
        step();
        check("pix_cell4", 32'(pixel_out), 32'h444);

        chk_pix(340, 100, 12'hFFF, "sep_col");
        chk_pix(0, 383, 12'hFFF, "sep_row");
        chk_pix(1000, 100, 12'h000, "background");
        chk_pix(46, 28, 12'hF00, "ring_tl");
        chk_pix(293, 355, 12'hF00, "ring_br");
        chk_pix(45, 28, 12'h000, "ring_out_left");
        chk_pix(294, 355, 12'h000, "ring_out_right");
        chk_pix(46, 27, 12'h000, "ring_out_top");
        chk_pix(386, 28, 12'h000, "ring_cell1_off");

        press_right();
        hcount_in = 11'd500; vcount_in = 10'd200; step();
        check("sel_before_commit", 32'(select_out), 32'd0);
        commit();
        check("commit_next", 32'(select_out), 32'd1);
        chk_pix(386, 28, 12'hF00, "ring_cell1_on");
        chk_pix(46, 28, 12'h000, "ring_cell0_off");

        right_in = 1'b1;
        step();
        commit();
        commit();
        commit();
        right_in = 1'b0;
        step();
        check("hold_once", 32'(select_out), 32'd2);

        press_right(); commit();
        press_right(); commit();
        press_right(); commit();
        check("sel_five", 32'(select_out), 32'd5);
        press_right(); commit();
        check("wrap_next", 32'(select_out), 32'd0);
        press_left(); commit();
        check("wrap_prev", 32'(select_out), 32'd5);

        left_in = 1'b1; right_in = 1'b1; step();
        left_in = 1'b0; right_in = 1'b0; step();
        commit();
        check("both_rise", 32'(select_out), 32'd5);

        hcount_in = 11'd0; vcount_in = 10'd768; right_in = 1'b1; step();
        hcount_in = 11'd1; step();
        check("press_on_commit", 32'(select_out), 32'd5);
        right_in = 1'b0; step();
        commit();
        check("held_applied", 32'(select_out), 32'd0);

        ready = 1'b0;
        chk_pix(340, 100, 12'h000, "ready_low_pix");
        press_left();
        commit();
        check("ready_low_commit", 32'(select_out), 32'd0);
        ready = 1'b1;
        commit();
        check("ready_commit", 32'(select_out), 32'd5);

        hcount_in = 11'd340; vcount_in = 10'd100;
        rst_in = 1'b1; step();
        check("midrst_select", 32'(select_out), 32'd0);
        check("midrst_pixel", 32'(pixel_out), 32'h000);
        rst_in = 1'b0; step();
        check("refill_1", 32'(pixel_out), 32'h000);
        step();
        check("refill_2", 32'(pixel_out), 32'hFFF);

`ifdef GRID_CONFIRM_EN
        confirm_in = 1'b1; step();
        confirm_in = 1'b0; step();
        check("lock_on", 32'(locked_out), 32'd1);
        chk_pix(46, 28, 12'h0F0, "lock_ring");
        press_right(); commit();
        check("lock_no_move", 32'(select_out), 32'd0);
        confirm_in = 1'b1; step();
        confirm_in = 1'b0; step();
        check("lock_off", 32'(locked_out), 32'd0);
        chk_pix(46, 28, 12'hF00, "unlock_ring");
`else
        check("locked_tied", 32'(locked_out), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
